// File: rtl/lock_pkg.sv
// Shared definitions for the lock code sender: FSM state encoding and
// default timing/length values used by the top-level parameters.
package lock_pkg;

  localparam int DEF_MAX_LEN    = 8;
  localparam int DEF_PULSE_CYC  = 4;
  localparam int DEF_GAP_CYC    = 4;
  localparam int DEF_SETTLE_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_PULSE = 3'd1,
    ST_RST_GAP   = 3'd2,
    ST_BIT_PULSE = 3'd3,
    ST_BIT_GAP   = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_REPORT    = 3'd6
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops before anyone looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lock_code_sender.sv
// Drives a lock's RESET/ZERO/ONE buttons to enter a code, waits for the lock
// to settle, then reports its synchronized UNLOCK level with a done pulse.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [MAX_LEN-1:0]             code_bits,
  input  logic [$clog2(MAX_LEN+1)-1:0]   code_len,
  input  logic                           reset_first,
  output logic                           reset_btn,
  output logic                           zero_btn,
  output logic                           one_btn,
  input  logic                           unlock_in,
  output logic                           done,
  output logic                           unlocked,
  output logic                           busy
);

  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC)
                         ? ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC)
                         : ((GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [LW-1:0]      idx, idx_nxt;
  logic [LW-1:0]      len_q, len_nxt, len_clamped;
  logic [MAX_LEN-1:0] code_q, code_nxt;
  logic               unlocked_nxt;
  logic               bit_nxt;
  logic               unlock_sync;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (unlock_in),
    .q   (unlock_sync)
  );

  assign len_clamped = (code_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : code_len;

  // Next-state, counter, bit index and capture logic for the press sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    idx_nxt      = idx;
    len_nxt      = len_q;
    code_nxt     = code_q;
    unlocked_nxt = unlocked;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start_valid) begin
          code_nxt = code_bits;
          len_nxt  = len_clamped;
          idx_nxt  = '0;
          if (reset_first)            state_nxt = ST_RST_PULSE;
          else if (len_clamped == '0) state_nxt = ST_SETTLE;
          else                        state_nxt = ST_BIT_PULSE;
        end
      end
      ST_RST_PULSE: begin
        if (cnt == CW'(PULSE_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_RST_GAP;
        end
      end
      ST_RST_GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (len_q == '0) ? ST_SETTLE : ST_BIT_PULSE;
        end
      end
      ST_BIT_PULSE: begin
        if (cnt == CW'(PULSE_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_BIT_GAP;
        end
      end
      ST_BIT_GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_nxt   = '0;
          idx_nxt   = idx + 1'b1;
          state_nxt = ((idx + 1'b1) < len_q) ? ST_BIT_PULSE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          cnt_nxt      = '0;
          unlocked_nxt = unlock_sync;
          state_nxt    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Code bit that the next BIT_PULSE cycle will present.
  assign bit_nxt = |(code_nxt & (MAX_LEN'(1) << idx_nxt));

  // Register state and decode outputs from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      len_q       <= '0;
      code_q      <= '0;
      reset_btn   <= 1'b0;
      zero_btn    <= 1'b0;
      one_btn     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      unlocked    <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      len_q       <= len_nxt;
      code_q      <= code_nxt;
      reset_btn   <= (state_nxt == ST_RST_PULSE);
      zero_btn    <= (state_nxt == ST_BIT_PULSE) && !bit_nxt;
      one_btn     <= (state_nxt == ST_BIT_PULSE) &&  bit_nxt;
      done        <= (state_nxt == ST_REPORT);
      busy        <= (state_nxt != ST_IDLE);
      unlocked    <= unlocked_nxt;
      start_ready <= (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Self-checking bench for lock_code_sender: directed timing scenarios plus
// random requests compared cycle by cycle against a press-list model.
module tb_lock_code_sender;

  localparam int ML = 8;
  localparam int P  = 4;
  localparam int G  = 4;
  localparam int S  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] code_bits = '0;
  logic [3:0] code_len = '0;
  logic       reset_first = 1'b0;
  logic       reset_btn, zero_btn, one_btn;
  logic       unlock_in = 1'b0;
  logic       done, unlocked, busy;

  int   total = 0;
  int   bad = 0;
  logic prev_unl = 1'b0;

  lock_code_sender #(
    .MAX_LEN    (ML),
    .PULSE_CYC  (P),
    .GAP_CYC    (G),
    .SETTLE_CYC (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .code_bits   (code_bits),
    .code_len    (code_len),
    .reset_first (reset_first),
    .reset_btn   (reset_btn),
    .zero_btn    (zero_btn),
    .one_btn     (one_btn),
    .unlock_in   (unlock_in),
    .done        (done),
    .unlocked    (unlocked),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at the falling edge of the request cycle T. Builds the expected
  // button trace as a list of presses (1=RESET, 2=ZERO, 3=ONE, 0=idle),
  // then checks every cycle T+1 .. done. abort_at>0 pulses rst in that cycle.
  task automatic run_seq(input logic [7:0] bits, input int len, input logic rf,
                         input int unlock_from, input bit keep_valid, input int abort_at);
    int       q[$];
    int       eff;
    int       n;
    logic     exp_unl;
    logic [2:0] exp_btn;
    logic [2:0] got_btn;
    eff = (len > ML) ? ML : len;
    if (rf) begin
      repeat (P) q.push_back(1);
      repeat (G) q.push_back(0);
    end
    for (int i = 0; i < eff; i++) begin
      repeat (P) q.push_back(bits[i] ? 3 : 2);
      repeat (G) q.push_back(0);
    end
    repeat (S) q.push_back(0);
    n = q.size() + 1;
    exp_unl = (unlock_from >= 0 && unlock_from <= n - 3);

    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_at_T: got %b want 1", start_ready);
    end
    total++;
    if (unlocked !== prev_unl) begin
      bad++;
      $display("FAIL unlocked_hold: got %b want %b", unlocked, prev_unl);
    end

    code_bits   = bits;
    code_len    = 4'(len);
    reset_first = rf;
    start_valid = 1'b1;
    unlock_in   = (unlock_from == 0);

    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!keep_valid) start_valid = 1'b0;
      case ((c < n) ? q[c-1] : 0)
        1:       exp_btn = 3'b100;
        2:       exp_btn = 3'b010;
        3:       exp_btn = 3'b001;
        default: exp_btn = 3'b000;
      endcase
      got_btn = {reset_btn, zero_btn, one_btn};
      total++;
      if (got_btn !== exp_btn) begin
        bad++;
        $display("FAIL buttons T+%0d: got %b want %b (len=%0d rf=%b bits=%h)",
                 c, got_btn, exp_btn, len, rf, bits);
      end
      total++;
      if ($countones(got_btn) > 1) begin
        bad++;
        $display("FAIL onehot T+%0d: got %b", c, got_btn);
      end
      total++;
      if (done !== (c == n)) begin
        bad++;
        $display("FAIL done T+%0d: got %b want %b", c, done, (c == n));
      end
      total++;
      if (busy !== 1'b1 || start_ready !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready T+%0d: got busy=%b ready=%b want 1/0", c, busy, start_ready);
      end
      if (c == n) begin
        total++;
        if (unlocked !== exp_unl) begin
          bad++;
          $display("FAIL unlocked T+%0d: got %b want %b", c, unlocked, exp_unl);
        end
        prev_unl = exp_unl;
      end
      unlock_in = (unlock_from >= 0 && c >= unlock_from);

      if (c == abort_at) begin
        rst = 1'b1;
        start_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({reset_btn, zero_btn, one_btn, done, busy, unlocked} !== 6'b0 || start_ready !== 1'b1) begin
          bad++;
          $display("FAIL abort T+%0d: got btn=%b%b%b done=%b busy=%b unl=%b ready=%b want 0s/ready=1",
                   c + 1, reset_btn, zero_btn, one_btn, done, busy, unlocked, start_ready);
        end
        rst = 1'b0;
        prev_unl = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          total++;
          if ({reset_btn, zero_btn, one_btn, done} !== 4'b0) begin
            bad++;
            $display("FAIL post_abort +%0d: got btn=%b%b%b done=%b want 0",
                     k, reset_btn, zero_btn, one_btn, done);
          end
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b1;
    unlock_in = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({reset_btn, zero_btn, one_btn, done, busy, unlocked} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b want 000000",
               reset_btn, zero_btn, one_btn, done, busy, unlocked);
    end
    rst = 1'b0;
    start_valid = 1'b0;
    unlock_in = 1'b0;
    prev_unl = 1'b0;
    @(negedge clk);
    total++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_reset: got ready=%b busy=%b want 1/0", start_ready, busy);
    end
  endtask

  task automatic test_code_101_unlock_high();
    @(negedge clk);
    run_seq(8'b101, 3, 1'b0, 20, 1'b0, 0);
  endtask

  task automatic test_code_101_unlock_low();
    @(negedge clk);
    run_seq(8'b101, 3, 1'b0, -1, 1'b0, 0);
  endtask

  task automatic test_reset_first();
    @(negedge clk);
    run_seq(8'b0, 1, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    run_seq(8'hff, 0, 1'b0, -1, 1'b0, 0);
    @(negedge clk);
    run_seq(8'hff, 0, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_clamp();
    @(negedge clk);
    run_seq(8'ha5, 12, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
    run_seq(8'h3c, 8, 1'b1, -1, 1'b0, 0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    run_seq(8'b101, 3, 1'b0, 0, 1'b0, 10);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_seq(8'b0110, 4, 1'b0, -1, 1'b1, 0);
    @(negedge clk);
    run_seq(8'b0011, 2, 1'b1, 0, 1'b1, 0);
    @(negedge clk);
    run_seq(8'b1, 0, 1'b0, -1, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [7:0] bits;
    int         len;
    logic       rf;
    int         unl;
    for (int i = 0; i < 25; i++) begin
      bits = 8'($urandom);
      len  = $urandom_range(0, 13);
      rf   = 1'($urandom_range(0, 1));
      unl  = ($urandom_range(0, 1) == 1) ? 0 : -1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_seq(bits, len, rf, unl, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_code_101_unlock_high();
    test_code_101_unlock_low();
    test_reset_first();
    test_zero_len();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
